// File: rtl/logic_pkg.sv
// Shared encodings for the logic-function pipeline: op codes and the
// entry-count states of the output handshake.
package logic_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_AND   = 3'b000;
    localparam logic [OPW-1:0] OP_OR    = 3'b001;
    localparam logic [OPW-1:0] OP_XOR   = 3'b010;
    localparam logic [OPW-1:0] OP_NOR   = 3'b011;
    localparam logic [OPW-1:0] OP_NAND  = 3'b100;
    localparam logic [OPW-1:0] OP_XNOR  = 3'b101;
    localparam logic [OPW-1:0] OP_ANDN  = 3'b110;
    localparam logic [OPW-1:0] OP_PASSA = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/logic_pipe_if.sv
// Operand/result handshake bundle between decode, the logic pipe and the
// ALU result mux.
interface logic_pipe_if
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, zero
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, zero
    );
endinterface

// File: rtl/logic_core.sv
// Combinational bitwise function evaluator with zero flag; shared with the
// ALU, so it carries no state.
module logic_core
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [OPW-1:0]   i_op,
    output logic [WIDTH-1:0] o_y,
    output logic             o_zero
);
    logic [WIDTH-1:0] w_y;

    always_comb begin
        w_y = '0;
        unique case (i_op)
            OP_AND:   w_y = i_a & i_b;
            OP_OR:    w_y = i_a | i_b;
            OP_XOR:   w_y = i_a ^ i_b;
            OP_NOR:   w_y = ~(i_a | i_b);
            OP_NAND:  w_y = ~(i_a & i_b);
            OP_XNOR:  w_y = ~(i_a ^ i_b);
            OP_ANDN:  w_y = i_a & ~i_b;
            OP_PASSA: w_y = i_a;
            default:  w_y = '0;
        endcase
    end

    assign o_y    = w_y;
    assign o_zero = ~|w_y;
endmodule

// File: rtl/logic_pipe.sv
// Registered logic unit: evaluates at accept, then holds results in an
// output register backed by a one-entry skid so in_ready stays a pure flop.
module logic_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    logic_pipe_if.slave  bus
);
    logic [WIDTH-1:0] w_res;
    logic             w_res_zero;

    logic_core #(.WIDTH(WIDTH)) u_core (
        .i_a    (bus.a),
        .i_b    (bus.b),
        .i_op   (bus.op),
        .o_y    (w_res),
        .o_zero (w_res_zero)
    );

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic [WIDTH-1:0] r_skid_y;
    logic             r_skid_zero;

    logic w_acc;
    logic w_dlv;
    logic w_load_out;
    logic w_load_skid;
    logic w_skid_to_out;

    assign w_acc = bus.in_valid && r_in_ready;
    assign w_dlv = r_out_valid && bus.out_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt = ST_ONE;
                    w_load_out  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_acc && w_dlv) begin
                    w_load_out = 1'b1;
                end else if (w_acc) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_dlv) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_dlv) begin
                    w_state_nxt   = ST_ONE;
                    w_skid_to_out = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Ready/valid are decoded from the next state so both leave as flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_zero      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            if (w_load_out) begin
                r_y    <= w_res;
                r_zero <= w_res_zero;
            end else if (w_skid_to_out) begin
                r_y    <= r_skid_y;
                r_zero <= r_skid_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_skid) begin
            r_skid_y    <= w_res;
            r_skid_zero <= w_res_zero;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;
    assign bus.zero      = r_zero;
endmodule

// File: tb/tb_logic_pipe.sv
// Directed and randomized checks of logic_pipe at WIDTH 32, 8 and 1.
module tb_logic_pipe;
    import logic_pkg::*;

    localparam int N_RAND = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_pipe_if #(.WIDTH(32)) m32 ();
    logic_pipe_if #(.WIDTH(8))  m8 ();
    logic_pipe_if #(.WIDTH(1))  m1 ();

    logic_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(m32.slave));
    logic_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(m8.slave));
    logic_pipe #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(m1.slave));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: each op is its 2-input truth table, indexed by {a_bit, b_bit}.
    function automatic logic [63:0] ref_y(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
        logic [3:0]  tt;
        logic [63:0] r;
        case (op)
            3'd0: tt = 4'b1000;
            3'd1: tt = 4'b1110;
            3'd2: tt = 4'b0110;
            3'd3: tt = 4'b0001;
            3'd4: tt = 4'b0111;
            3'd5: tt = 4'b1001;
            3'd6: tt = 4'b0100;
            default: tt = 4'b1100;
        endcase
        r = '0;
        for (int i = 0; i < w; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    logic [31:0] exp8 [8];
    logic [31:0] W [8];
    logic [63:0] q8 [$];
    logic [63:0] q1 [$];

    int          acc_n [2];
    int          dl_n [2];
    int          widths [2];
    logic        rv [2], rr [2], stall_p [2];
    logic [63:0] ra [2], rb [2], sy [2];
    logic [2:0]  rop [2];
    logic        sz [2];
    logic        ov [2], oz [2], ir [2];
    logic [63:0] oy [2];

    initial begin
        int send, got;
        logic [63:0] e;

        exp8 = '{32'hAAAA_0000, 32'hFFFF_5555, 32'h5555_5555, 32'h0000_AAAA,
                 32'h5555_FFFF, 32'hAAAA_AAAA, 32'h0000_5555, 32'hAAAA_5555};
        W = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
              32'h5555_0005, 32'h6666_0006, 32'h7777_0007, 32'h8888_0008};
        m32.in_valid = 0; m32.a = '0; m32.b = '0; m32.op = '0; m32.out_ready = 0;
        m8.in_valid  = 0; m8.a  = '0; m8.b  = '0; m8.op  = '0; m8.out_ready  = 0;
        m1.in_valid  = 0; m1.a  = '0; m1.b  = '0; m1.op  = '0; m1.out_ready  = 0;

        #12;
        check("rst_in_ready", m32.in_ready, 0);
        check("rst_out_valid", m32.out_valid, 0);
        check("rst_y", m32.y, 0);
        check("rst_zero", m32.zero, 1);
        check("rst_out_valid_w8", m8.out_valid, 0);
        check("rst_zero_w1", m1.zero, 1);

        @(negedge clk);
        rst_n = 1;
        #1 check("in_ready_before_edge", m32.in_ready, 0);
        @(negedge clk);
        check("in_ready_after_release", m32.in_ready, 1);

        // Single NOR
        m32.a = 32'hF0F0_1234; m32.b = 32'h0FF0_FFFF; m32.op = OP_NOR; m32.in_valid = 1;
        check("nor_pre_valid", m32.out_valid, 0);
        @(negedge clk);
        m32.in_valid = 0;
        check("nor_valid", m32.out_valid, 1);
        check("nor_y", m32.y, 64'h000F_0000);
        check("nor_zero", m32.zero, 0);
        m32.out_ready = 1;
        @(negedge clk);
        check("nor_drained", m32.out_valid, 0);

        // All eight ops back to back
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                check("op8_valid", m32.out_valid, 1);
                check($sformatf("op8_y_%0d", i - 1), m32.y, exp8[i-1]);
                check("op8_in_ready", m32.in_ready, 1);
            end
            if (i < 8) begin
                m32.a = 32'hAAAA_5555; m32.b = 32'hFFFF_0000; m32.op = 3'(i); m32.in_valid = 1;
            end else begin
                m32.in_valid = 0;
            end
            @(negedge clk);
        end
        check("op8_drained", m32.out_valid, 0);

        // Zero flag
        m32.a = 32'h1234_5678; m32.b = 32'h1234_5678; m32.op = OP_XOR; m32.in_valid = 1;
        @(negedge clk);
        m32.in_valid = 0;
        check("zf_valid", m32.out_valid, 1);
        check("zf_y", m32.y, 0);
        check("zf_zero", m32.zero, 1);
        @(negedge clk);

        // Backpressure
        m32.out_ready = 0; m32.op = OP_PASSA; m32.b = 32'hDEAD_BEEF;
        m32.a = W[0]; m32.in_valid = 1;
        check("bp_ready_w1", m32.in_ready, 1);
        @(negedge clk);
        m32.a = W[1];
        check("bp_ready_w2", m32.in_ready, 1);
        check("bp_y_w1", m32.y, W[0]);
        @(negedge clk);
        m32.a = W[2];
        check("bp_full", m32.in_ready, 0);
        check("bp_hold_y", m32.y, W[0]);
        repeat (3) begin
            @(negedge clk);
            check("bp_stall_ready", m32.in_ready, 0);
            check("bp_stall_y", m32.y, W[0]);
            check("bp_stall_valid", m32.out_valid, 1);
        end
        send = 2; got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            m32.out_ready = 1;
            if (send < 4) begin m32.in_valid = 1; m32.a = W[send]; end
            else m32.in_valid = 0;
            if (m32.in_valid && m32.in_ready) send++;
            if (m32.out_valid) begin
                check($sformatf("bp_order_%0d", got), m32.y, W[got]);
                got++;
            end
            @(negedge clk);
        end
        m32.in_valid = 0;
        check("bp_count", got, 4);

        // Reset while full and stalled
        m32.out_ready = 0;
        m32.a = W[4]; m32.in_valid = 1;
        @(negedge clk);
        m32.a = W[5];
        @(negedge clk);
        m32.in_valid = 0;
        check("rs_full", m32.in_ready, 0);
        check("rs_valid", m32.out_valid, 1);
        #3 rst_n = 0;
        #1;
        check("rs_async_valid", m32.out_valid, 0);
        check("rs_async_y", m32.y, 0);
        check("rs_async_zero", m32.zero, 1);
        check("rs_async_ready", m32.in_ready, 0);
        @(negedge clk);
        rst_n = 1;
        m32.out_ready = 1;
        repeat (4) begin
            @(negedge clk);
            check("rs_no_stale", m32.out_valid, 0);
        end
        m32.a = W[6]; m32.in_valid = 1;
        @(negedge clk);
        m32.in_valid = 0;
        check("rs_new_valid", m32.out_valid, 1);
        check("rs_new_y", m32.y, W[6]);
        @(negedge clk);
        check("rs_new_drained", m32.out_valid, 0);

        // Randomized traffic on WIDTH=8 and WIDTH=1
        widths = '{8, 1};
        for (int k = 0; k < 2; k++) begin
            acc_n[k] = 0; dl_n[k] = 0; rv[k] = 0; rr[k] = 0; stall_p[k] = 0;
            ra[k] = '0; rb[k] = '0; rop[k] = '0; sy[k] = '0; sz[k] = 0;
        end
        for (int cyc = 0; cyc < 60000 && (dl_n[0] < N_RAND || dl_n[1] < N_RAND); cyc++) begin
            @(negedge clk);
            ov[0] = m8.out_valid; oy[0] = 64'(m8.y); oz[0] = m8.zero; ir[0] = m8.in_ready;
            ov[1] = m1.out_valid; oy[1] = 64'(m1.y); oz[1] = m1.zero; ir[1] = m1.in_ready;
            for (int k = 0; k < 2; k++) begin
                if (stall_p[k]) begin
                    check("stall_valid", ov[k], 1);
                    check("stall_y", oy[k], sy[k]);
                    check("stall_zero", oz[k], sz[k]);
                end
                if (!(rv[k] && !ir[k])) begin
                    rv[k]  = (acc_n[k] < N_RAND) && ($urandom_range(0, 9) < 7);
                    ra[k]  = {$urandom, $urandom} & ((64'h1 << widths[k]) - 1);
                    rb[k]  = {$urandom, $urandom} & ((64'h1 << widths[k]) - 1);
                    rop[k] = 3'($urandom_range(0, 7));
                end
                rr[k] = ($urandom_range(0, 9) < 6);
                if (ov[k] && rr[k]) begin
                    if (k == 0) begin
                        check("rnd_w8_nodup", q8.size() > 0, 1);
                        if (q8.size() > 0) begin
                            e = q8.pop_front();
                            check("rnd_w8_y", oy[k], e);
                            check("rnd_w8_zero", oz[k], e == 0);
                        end
                    end else begin
                        check("rnd_w1_nodup", q1.size() > 0, 1);
                        if (q1.size() > 0) begin
                            e = q1.pop_front();
                            check("rnd_w1_y", oy[k], e);
                            check("rnd_w1_zero", oz[k], e == 0);
                        end
                    end
                    dl_n[k]++;
                end
                if (rv[k] && ir[k]) begin
                    e = ref_y(rop[k], ra[k], rb[k], widths[k]);
                    if (k == 0) q8.push_back(e); else q1.push_back(e);
                    acc_n[k]++;
                end
                stall_p[k] = ov[k] && !rr[k];
                sy[k] = oy[k];
                sz[k] = oz[k];
            end
            m8.in_valid = rv[0]; m8.a = ra[0][7:0]; m8.b = rb[0][7:0];
            m8.op = rop[0]; m8.out_ready = rr[0];
            m1.in_valid = rv[1]; m1.a = ra[1][0:0]; m1.b = rb[1][0:0];
            m1.op = rop[1]; m1.out_ready = rr[1];
        end
        check("rnd_w8_delivered", dl_n[0], N_RAND);
        check("rnd_w1_delivered", dl_n[1], N_RAND);
        check("rnd_w8_leftover", q8.size(), 0);
        check("rnd_w1_leftover", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
